// File: rtl/wb_arbiter.sv
// wb_arbiter: load-priority writeback arbiter with bounded ALU starvation driving the register file write port
module wb_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_stall,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    output logic [4:0]  write,
    output logic [31:0] write_data,
    output logic        RegWrite,
    output logic [4:0]  pending_rd,
    output logic [3:0]  starve_cnt
);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    logic        go, force_alu;
    logic [3:0]  starve_q, starve_d;
    logic [4:0]  write_q;
    logic [31:0] data_q;
    logic        regwrite_q;
    always_comb begin
        go        = rst_n && !wb_stall;
        force_alu = starve_q == SMAX;
        ld_ready  = go && ld_valid && !(alu_valid && force_alu);
        alu_ready = go && alu_valid && (!ld_valid || force_alu);
        starve_d  = alu_ready ? 4'd0
                  : (alu_valid && ld_ready && starve_q < SMAX) ? starve_q + 4'd1
                  : starve_q;
    end
    // x0 writes still capture index/data but never raise the write enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q   <= '0;
            write_q    <= '0;
            data_q     <= '0;
            regwrite_q <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            regwrite_q <= (ld_ready && ld_rd != 5'd0) || (alu_ready && alu_rd != 5'd0);
            if (ld_ready) begin
                write_q <= ld_rd;
                data_q  <= ld_data;
            end else if (alu_ready) begin
                write_q <= alu_rd;
                data_q  <= alu_data;
            end
        end
    end
    assign write      = write_q;
    assign write_data = data_q;
    assign RegWrite   = regwrite_q;
    assign pending_rd = write_q;
    assign starve_cnt = starve_q;
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and sequencer for the RV32I integer register file's single write port. It accepts completed results from two requesters, the ALU path and the load path, over valid/ready handshakes. It selects one per cycle with load priority and a bounded-starvation guarantee for the ALU, registers the winner, and drives the register file's `write`, `write_data` and `RegWrite` inputs one cycle later. It sits between the execute/memory stages and the register file.

## Interface
Parameters:
- `STARVE_MAX`, default 3: consecutive ALU losses after which the ALU is forced to win. Legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `wb_stall`  in  1  global writeback freeze; when high, no requester is accepted.
- `alu_valid`  in  1  ALU result is offered.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `alu_ready`  out  1  ALU offer is accepted this cycle.
- `ld_valid`  in  1  load result is offered.
- `ld_rd`  in  5  load destination register.
- `ld_data`  in  32  load result.
- `ld_ready`  out  1  load offer is accepted this cycle.
- `write`  out  5  register file write index (registered).
- `write_data`  out  32  register file write data (registered).
- `RegWrite`  out  1  register file write enable (registered, one-cycle pulse per accepted write).
- `pending_rd`  out  5  destination of the write currently presented on the port; valid when `RegWrite`=1.
- `starve_cnt`  out  4  current ALU starvation count, for debug and verification.

## Operation
- Grant is combinational from the valid inputs and `starve_cnt`:
  - If `wb_stall`=1: no grant, both readies are 0.
  - Only one requester valid: that requester is granted.
  - Both valid and `starve_cnt` < `STARVE_MAX`: load is granted.
  - Both valid and `starve_cnt` == `STARVE_MAX`: ALU is granted.
- Ready signals:
  - `ld_ready` = grant_ld; `alu_ready` = grant_alu.
  - Readies never assert without the matching valid.
  - At most one ready is high per cycle.
- Accept: a requester is accepted when its valid and ready are both high. The accepted `rd` and data are captured into the output register.
- x0 filtering: an accepted write with `rd`=0 completes its handshake but produces `RegWrite`=0 next cycle. `write` and `write_data` still update.
- Starvation counter update:
  - Increments when `alu_valid`=1 and the load is granted.
  - Clears to 0 when the ALU is accepted.
  - Holds otherwise, including when `wb_stall`=1.
  - Saturates at `STARVE_MAX`.
- A requester that is not granted keeps valid high with its payload stable until accepted. The arbiter does not buffer losers.

## Timing
- Latency: accept in cycle N, then `write`, `write_data` and `RegWrite`=1 in cycle N+1. `RegWrite` is low in any cycle not preceded by an accept of a non-x0 write.
- Throughput: one write per cycle. Back-to-back accepts give consecutive `RegWrite` pulses.
- The register file is written in the cycle `RegWrite` is high. Downstream readers must treat `pending_rd` as a hazard for that one cycle.
- Reset: with `rst_n`=0 at a rising edge, the following all become 0 at that edge:
  - `write`, `write_data`, `RegWrite`, `pending_rd`, `starve_cnt`.
- Readies are forced to 0 while `rst_n`=0.
- A write accepted in the same cycle as reset is dropped; no `RegWrite` follows.
- Simultaneous `wb_stall` and the starvation threshold: the stall wins and the counter holds. The ALU is granted on the first unstalled cycle where both requesters are valid.
- If `ld_valid` drops while `starve_cnt`=`STARVE_MAX`, the ALU is granted as the sole requester and the counter clears.

## Test plan
- Single ALU write: `alu_valid`=1, `alu_rd`=5, `alu_data`=0xDEADBEEF in cycle N. Required: `alu_ready`=1 in N; `RegWrite`=1, `write`=5, `write_data`=0xDEADBEEF in N+1; `RegWrite`=0 in N+2.
- Contention and starvation with `STARVE_MAX`=3: both valid continuously with distinct rd values. Required grant sequence LD, LD, LD, ALU, LD, ...; `starve_cnt` runs 0,1,2,3,0.
- x0 write: `ld_valid`=1, `ld_rd`=0, `ld_data`=0x1234. Required: `ld_ready`=1, then `RegWrite`=0 in the following cycle.
- Stall: both valid with `wb_stall`=1 for 4 cycles. Required: both readies 0, `RegWrite`=0, `starve_cnt` unchanged; normal grants resume on the first unstalled cycle.
- Reset mid-operation: accept an ALU write with `rd`=7 in the same cycle `rst_n`=0. Required: next cycle `RegWrite`=0, all outputs 0, `starve_cnt`=0.
- Back-to-back: alternating sole requesters LD `rd`=1, ALU `rd`=2, LD `rd`=3 on consecutive cycles. Required: three consecutive `RegWrite` pulses with `write`=1, 2, 3 and matching data.
